// File: rtl/hsync_rx.sv
// Horizontal sync receiver: measures incoming hsync period/width on pixel strobes,
// locks a flywheel position counter and regenerates visible enable and column index.
//
// state  | meaning
// SEARCH | no line reference; waiting for the first hsync rise
// VERIFY | counting consecutive good lines toward lock
// LOCKED | flywheel aligned; outputs active, counting consecutive bad lines
`timescale 1ns/1ps
module hsync_rx #(
  parameter int H_PULSE       = 96,
  parameter int H_BACK_END    = 144,
  parameter int H_VISIBLE_END = 784,
  parameter int H_TOTAL       = 800,
  parameter int CNT_BIT       = 10,
  parameter int LOCK_LINES    = 4,
  parameter int UNLOCK_MISSES = 2
) (
  input  logic               clk,
  input  logic               i_arst_n,
  input  logic               i_px_clk,
  input  logic               i_hsync,
  output logic               o_locked,
  output logic               o_addr_en,
  output logic [CNT_BIT-1:0] o_x,
  output logic               o_line_start,
  output logic               o_err
);

  localparam int GW = $clog2(LOCK_LINES + 1);
  localparam int MW = $clog2(UNLOCK_MISSES + 1);

  localparam logic [CNT_BIT-1:0] TOTAL_C = CNT_BIT'(H_TOTAL);
  localparam logic [CNT_BIT-1:0] PULSE_C = CNT_BIT'(H_PULSE);
  localparam logic [CNT_BIT-1:0] BACK_C  = CNT_BIT'(H_BACK_END);
  localparam logic [CNT_BIT-1:0] VEND_C  = CNT_BIT'(H_VISIBLE_END);
  localparam logic [GW-1:0]      LOCK_C  = GW'(LOCK_LINES);
  localparam logic [MW-1:0]      MISS_C  = MW'(UNLOCK_MISSES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t             state, state_nx;
  logic [CNT_BIT-1:0] pos, pos_inc, pos_nx, width;
  logic               hsync_q, fall_seen, dbl_fall;
  logic [GW-1:0]      good_cnt, good_inc, good_nx;
  logic [MW-1:0]      miss_cnt, miss_inc, miss_nx;
  logic               rise, fall, at_end, line_end, line_good, bad_evt;
  logic               locked_nx, vis_nx;

  always_comb begin
    rise      = i_px_clk & i_hsync & ~hsync_q;
    fall      = i_px_clk & ~i_hsync & hsync_q;
    pos_inc   = pos + 1'b1;
    at_end    = (pos_inc == TOTAL_C);
    line_end  = i_px_clk & (rise | at_end);
    pos_nx    = (rise | at_end) ? '0 : pos_inc;
    // A rise landing exactly on the nominal period is the only way a line is good.
    line_good = rise & at_end & fall_seen & ~dbl_fall & (width == PULSE_C);
    good_inc  = good_cnt + 1'b1;
    miss_inc  = miss_cnt + 1'b1;
  end

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    miss_nx  = miss_cnt;
    bad_evt  = 1'b0;
    if (line_end) begin
      case (state)
        SEARCH: begin
          if (rise) begin
            state_nx = VERIFY;
            good_nx  = '0;
          end
        end
        VERIFY: begin
          if (line_good) begin
            good_nx = good_inc;
            if (good_inc == LOCK_C) begin
              state_nx = LOCKED;
              miss_nx  = '0;
            end
          end else if (rise) begin
            good_nx = '0;
          end else begin
            state_nx = SEARCH;
          end
        end
        LOCKED: begin
          if (line_good) begin
            miss_nx = '0;
          end else begin
            bad_evt = 1'b1;
            miss_nx = miss_inc;
            if (miss_inc == MISS_C) state_nx = SEARCH;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state     <= SEARCH;
      pos       <= '0;
      width     <= '0;
      hsync_q   <= 1'b0;
      fall_seen <= 1'b0;
      dbl_fall  <= 1'b0;
      good_cnt  <= '0;
      miss_cnt  <= '0;
    end else if (i_px_clk) begin
      state    <= state_nx;
      pos      <= pos_nx;
      hsync_q  <= i_hsync;
      good_cnt <= good_nx;
      miss_cnt <= miss_nx;
      if (fall) width <= pos_nx;
      // A fall on the line-end strobe belongs to the new line.
      if (line_end) begin
        fall_seen <= fall;
        dbl_fall  <= 1'b0;
      end else if (fall) begin
        fall_seen <= 1'b1;
        dbl_fall  <= dbl_fall | fall_seen;
      end
    end
  end

  always_comb begin
    locked_nx = (state_nx == LOCKED);
    vis_nx    = (pos_nx >= BACK_C) && (pos_nx < VEND_C);
  end

  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_addr_en    <= 1'b0;
      o_x          <= '0;
      o_line_start <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_line_start <= 1'b0;
      o_err        <= 1'b0;
      if (i_px_clk) begin
        o_addr_en    <= locked_nx & vis_nx;
        o_x          <= (locked_nx & vis_nx) ? (pos_nx - BACK_C) : '0;
        o_line_start <= locked_nx & (pos_nx == '0);
        o_err        <= locked_nx & bad_evt;
      end
    end
  end

  assign o_locked = (state == LOCKED);

endmodule

// File: tb/tb_hsync_rx.sv
// Scoreboard bench for hsync_rx: randomized strobe spacing and line shapes checked
// against a line-level reference model of the lock/flywheel rules.
`timescale 1ns/1ps
module tb_hsync_rx;
  localparam int H_PULSE = 96, H_BACK_END = 144, H_VISIBLE_END = 784, H_TOTAL = 800;
  localparam int LOCK_LINES = 4, UNLOCK_MISSES = 2;
  localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic       clk = 1'b0;
  logic       i_arst_n, i_px_clk, i_hsync;
  logic       o_locked, o_addr_en, o_line_start, o_err;
  logic [9:0] o_x;

  typedef struct packed {
    logic       locked;
    logic       addr_en;
    logic [9:0] x;
    logic       line_start;
    logic       err;
  } exp_t;

  exp_t q[$];
  exp_t held = '0;
  int   errors = 0, checks = 0;

  int m_pos, m_width, m_falls, m_mode, m_good, m_miss;
  bit m_hq;

  always #5 clk = ~clk;

  hsync_rx dut (
    .clk(clk), .i_arst_n(i_arst_n), .i_px_clk(i_px_clk), .i_hsync(i_hsync),
    .o_locked(o_locked), .o_addr_en(o_addr_en), .o_x(o_x),
    .o_line_start(o_line_start), .o_err(o_err)
  );

  function automatic void chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_width = 0; m_falls = 0; m_mode = M_SEARCH;
    m_good = 0; m_miss = 0; m_hq = 0;
  endfunction

  // One pixel strobe through the reference: a line is a stretch between p=0 events,
  // judged on its length, how it ended, and the single measured pulse width.
  function automatic exp_t model_step(bit hs);
    exp_t e;
    bit r, f, full, ev, good, bad;
    int p;
    r    = hs && !m_hq;
    f    = !hs && m_hq;
    full = (m_pos + 1 == H_TOTAL);
    ev   = r || full;
    p    = ev ? 0 : m_pos + 1;
    good = r && full && (m_falls == 1) && (m_width == H_PULSE);
    bad  = 0;
    if (ev) begin
      if (m_mode == M_SEARCH) begin
        if (r) begin m_mode = M_VERIFY; m_good = 0; end
      end else if (m_mode == M_VERIFY) begin
        if (good) begin
          m_good++;
          if (m_good == LOCK_LINES) begin m_mode = M_LOCKED; m_miss = 0; end
        end else if (r) m_good = 0;
        else m_mode = M_SEARCH;
      end else begin
        if (good) m_miss = 0;
        else begin
          bad = 1;
          m_miss++;
          if (m_miss == UNLOCK_MISSES) m_mode = M_SEARCH;
        end
      end
      m_falls = 0;
    end
    if (f) begin m_falls++; m_width = p; end
    m_hq  = hs;
    m_pos = p;
    e.locked     = (m_mode == M_LOCKED);
    e.addr_en    = e.locked && p >= H_BACK_END && p < H_VISIBLE_END;
    e.x          = e.addr_en ? 10'(p - H_BACK_END) : 10'd0;
    e.line_start = e.locked && p == 0;
    e.err        = e.locked && bad;
    return e;
  endfunction

  task automatic strobe(input bit hs);
    @(negedge clk);
    i_hsync  = hs;
    i_px_clk = 1'b1;
    q.push_back(model_step(hs));
    @(posedge clk);
    #2 i_px_clk = 1'b0;
    if ($urandom_range(0, 1) == 1) @(negedge clk);
  endtask

  task automatic send_line(input int period, input int width, input int start);
    for (int s = start; s < period; s++) strobe(s < width);
  endtask

  task automatic send_lines(input int n, input int period, input int width);
    for (int k = 0; k < n; k++) send_line(period, width, 0);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_locked"}, o_locked, 0);
    chk({tag, "_addr_en"}, o_addr_en, 0);
    chk({tag, "_x"}, o_x, 0);
    chk({tag, "_line_start"}, o_line_start, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  task automatic async_reset(string tag);
    @(posedge clk);
    #3;
    i_arst_n = 1'b0;
    i_px_clk = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    held = '0;
    q.delete();
    repeat (3) @(negedge clk);
    i_arst_n = 1'b1;
  endtask

  // Monitor: strobe cycles pop the scoreboard; other cycles must hold levels with no pulses.
  initial begin
    bit   s, r;
    exp_t e;
    forever begin
      @(posedge clk);
      s = i_px_clk;
      r = i_arst_n;
      #1;
      if (s && r) begin
        if (q.size() == 0) chk("scoreboard_underflow", 1, 0);
        else begin
          e = q.pop_front();
          chk("locked", o_locked, e.locked);
          chk("addr_en", o_addr_en, e.addr_en);
          chk("x", o_x, e.x);
          chk("line_start", o_line_start, e.line_start);
          chk("err", o_err, e.err);
          held = e;
        end
      end else begin
        chk("hold_locked", o_locked, held.locked);
        chk("hold_addr_en", o_addr_en, held.addr_en);
        chk("hold_x", o_x, held.x);
        chk("idle_line_start", o_line_start, 0);
        chk("idle_err", o_err, 0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int per, wid;
    i_arst_n = 1'b0;
    i_px_clk = 1'b0;
    i_hsync  = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    repeat (2) @(negedge clk);
    i_arst_n = 1'b1;

    // Ideal timing: lock arrives with the rise that completes good line 4.
    send_lines(4, H_TOTAL, H_PULSE);
    chk("not_locked_before_4th_end", o_locked, 0);
    strobe(1'b1);
    chk("locked_at_4th_end", o_locked, 1);
    chk("line_start_at_lock", o_line_start, 1);
    send_line(H_TOTAL, H_PULSE, 1);
    send_lines(1, H_TOTAL, H_PULSE);

    // Narrow pulse once, recover, then twice in a row.
    send_lines(1, H_TOTAL, 95);
    send_lines(1, H_TOTAL, H_PULSE);
    send_lines(2, H_TOTAL, 95);
    strobe(1'b1);
    chk("unlocked_after_two_narrow", o_locked, 0);
    send_line(H_TOTAL, H_PULSE, 1);
    send_lines(6, H_TOTAL, H_PULSE);
    chk("relocked_after_narrow", o_locked, 1);

    // Early rise realigns the flywheel.
    send_line(H_TOTAL, H_PULSE, 0);
    send_line(500, H_PULSE, 0);
    send_lines(2, H_TOTAL, H_PULSE);
    chk("locked_after_early_rise", o_locked, 1);

    // hsync disappears: flywheel keeps counting until two wraps drop lock.
    for (int s = 0; s < 1700; s++) strobe(1'b0);
    chk("unlocked_no_hsync", o_locked, 0);

    // Short period never locks; nominal period then locks.
    send_lines(4, 799, H_PULSE);
    send_lines(4, H_TOTAL, H_PULSE);
    chk("never_locked_799", o_locked, 0);
    strobe(1'b1);
    chk("locked_after_799_phase", o_locked, 1);
    send_line(H_TOTAL, H_PULSE, 1);

    // Reset in the visible area, then a full relock.
    send_line(H_TOTAL, H_PULSE, 0);
    send_line(400, H_PULSE, 0);
    chk("visible_before_reset", o_addr_en, 1);
    async_reset("midline_reset");
    send_lines(4, H_TOTAL, H_PULSE);
    chk("not_relocked_yet", o_locked, 0);
    strobe(1'b1);
    chk("relocked_after_reset", o_locked, 1);
    send_line(H_TOTAL, H_PULSE, 1);

    // Random mix of line shapes and dropouts.
    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 5))
        0:       per = 799;
        1:       per = 801;
        default: per = H_TOTAL;
      endcase
      case ($urandom_range(0, 3))
        0:       wid = 95;
        1:       wid = 97;
        default: wid = H_PULSE;
      endcase
      if ($urandom_range(0, 4) == 0)
        for (int s = 0; s < int'($urandom_range(1, 900)); s++) strobe(1'b0);
      else
        send_line(per, wid, 0);
    end
    send_lines(1, H_TOTAL, H_PULSE);

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
